// File: rtl/dct4_2d_seq_if.sv
// Row-in / column-out handshake bundle for the 4x4 two-pass DCT block.
interface dct4_2d_seq_if;
  logic               inverse;
  logic               i_valid;
  logic               i_ready;
  logic signed [15:0] i_row0, i_row1, i_row2, i_row3;
  logic               o_valid;
  logic               o_last;
  logic signed [15:0] o_data0, o_data1, o_data2, o_data3;
  logic               busy;

  modport slave (
    input  inverse, i_valid, i_row0, i_row1, i_row2, i_row3,
    output i_ready, o_valid, o_last, o_data0, o_data1, o_data2, o_data3, busy
  );

  modport master (
    output inverse, i_valid, i_row0, i_row1, i_row2, i_row3,
    input  i_ready, o_valid, o_last, o_data0, o_data1, o_data2, o_data3, busy
  );
endinterface

// File: rtl/dct4_2d_seq.sv
// 4x4 forward/inverse 2D DCT: rows in, pass 1 into a transpose buffer,
// pass 2 over buffer columns, one result column per beat out.

module dct4_lane #(
  parameter int LANE  = 0,
  parameter int VEC_W = 16,
  parameter int SUM_W = 27
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic                        inv_i,
  input  logic [3:0][VEC_W-1:0]       x_i,
  input  logic [3:0]                  shift_i,
  output logic signed [VEC_W-1:0]     res_o
);
  localparam logic signed [SUM_W-1:0] MAXV = SUM_W'(32767);
  localparam logic signed [SUM_W-1:0] MINV = -SUM_W'(32768);

  logic signed [SUM_W-1:0] sum_d, sum_q, rnd, shd;

  function automatic logic signed [7:0] mcoef(input logic [1:0] r, input logic [1:0] c);
    logic signed [7:0] v;
    v = 8'sd64;
    case (r)
      2'd0: v = 8'sd64;
      2'd1: case (c) 2'd0: v = 8'sd83; 2'd1: v = 8'sd36; 2'd2: v = -8'sd36; default: v = -8'sd83; endcase
      2'd2: v = (c == 2'd0 || c == 2'd3) ? 8'sd64 : -8'sd64;
      default: case (c) 2'd0: v = 8'sd36; 2'd1: v = -8'sd83; 2'd2: v = 8'sd83; default: v = -8'sd36; endcase
    endcase
    return v;
  endfunction

  // Lane LANE produces output element LANE; inverse walks the transposed row.
  always_comb begin
    sum_d = '0;
    for (int n = 0; n < 4; n++) begin
      sum_d = sum_d + SUM_W'(signed'(x_i[n])) *
              SUM_W'(inv_i ? mcoef(2'(n), 2'(LANE)) : mcoef(2'(LANE), 2'(n)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      sum_q <= '0;
    else if (en_i) sum_q <= sum_d;
  end

  always_comb begin
    rnd   = sum_q + (SUM_W'(1) << (shift_i - 4'd1));
    shd   = rnd >>> shift_i;
    res_o = shd[VEC_W-1:0];
    if (shd > MAXV)      res_o = 16'sh7fff;
    else if (shd < MINV) res_o = 16'sh8000;
  end
endmodule

module dct4_2d_seq (
  input  logic         clk,
  input  logic         rst,
  dct4_2d_seq_if.slave io
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;
  localparam int SUM_W     = 27;
  localparam int STAGES    = 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN1, PASS2, OUT} state_t;

  state_t                               state_q, state_d;
  logic [2:0]                           row_cnt_q, row_cnt_d;
  logic [1:0]                           col_cnt_q, col_cnt_d;
  logic [1:0]                           wr_cnt_q;
  logic                                 mode_q, mode_d;
  logic [STAGES:0]                      vld_pipe;
  logic                                 p2_q, last_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]      row_q, col_rd, x_mux, res, o_data_q;
  logic [NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] tbuf_q;
  logic                                 o_valid_q, o_last_q;
  logic                                 rdy, accept, issue, wr1, wr2;
  logic [3:0]                           shift;

  assign rdy    = (state_q == IDLE) || (state_q == LOAD);
  assign accept = io.i_valid && rdy;
  assign issue  = (state_q == PASS2);
  // vld_pipe[1] carries either a pass-1 row or a pass-2 column; p2_q tells which.
  assign wr1    = vld_pipe[1] && !p2_q;
  assign wr2    = vld_pipe[1] && p2_q;
  assign shift  = p2_q ? (mode_q ? 4'd12 : 4'd8) : (mode_q ? 4'd7 : 4'd1);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_col
    assign col_rd[n] = tbuf_q[n][col_cnt_q];
  end

  // Passes never overlap in the shared datapath, so a plain mux suffices.
  assign x_mux = vld_pipe[0] ? row_q : col_rd;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    dct4_lane #(.LANE(k), .VEC_W(VEC_W), .SUM_W(SUM_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (vld_pipe[0] | issue),
      .inv_i   (mode_q),
      .x_i     (x_mux),
      .shift_i (shift),
      .res_o   (res[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    mode_d    = mode_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = LOAD;
        row_cnt_d = 3'd1;
        mode_d    = io.inverse;
      end
      LOAD: if (accept) begin
        if (row_cnt_q == 3'd3) begin
          state_d   = DRAIN1;
          row_cnt_d = 3'd0;
        end else begin
          row_cnt_d = row_cnt_q + 3'd1;
        end
      end
      DRAIN1: if (wr1 && wr_cnt_q == 2'd3) begin
        state_d   = PASS2;
        col_cnt_d = 2'd0;
      end
      PASS2: begin
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'd3) state_d = OUT;
      end
      OUT: if (o_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      wr_cnt_q  <= '0;
      mode_q    <= 1'b0;
      vld_pipe  <= '0;
      p2_q      <= 1'b0;
      last_q    <= 1'b0;
      row_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      mode_q      <= mode_d;
      vld_pipe[0] <= accept;
      vld_pipe[1] <= vld_pipe[0] | issue;
      p2_q        <= issue;
      last_q      <= issue && (col_cnt_q == 2'd3);
      if (accept) begin
        row_q[0] <= io.i_row0;
        row_q[1] <= io.i_row1;
        row_q[2] <= io.i_row2;
        row_q[3] <= io.i_row3;
      end
      if (wr1) wr_cnt_q <= wr_cnt_q + 2'd1;
      o_valid_q <= wr2;
      o_last_q  <= wr2 && last_q;
      if (wr2) o_data_q <= res;
    end
  end

  // Transpose buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr1) tbuf_q[wr_cnt_q] <= res;
  end

  assign io.i_ready = rdy;
  assign io.busy    = (state_q != IDLE);
  assign io.o_valid = o_valid_q;
  assign io.o_last  = o_last_q;
  assign io.o_data0 = o_data_q[0];
  assign io.o_data1 = o_data_q[1];
  assign io.o_data2 = o_data_q[2];
  assign io.o_data3 = o_data_q[3];
endmodule

// File: tb/tb_dct4_2d_seq.sv
// Randomized bench for dct4_2d_seq against a matrix-arithmetic reference model.
module tb_dct4_2d_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   blk[4][4], ex[4][4], got[4][4];
  int   a0, a3;
  int   M[4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                    '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  dct4_2d_seq_if io();

  dct4_2d_seq dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got_v, input int exp_v);
    n_chk++;
    if (got_v == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
  endtask

  function automatic int od(input int r);
    case (r)
      0: return int'(io.o_data0);
      1: return int'(io.o_data1);
      2: return int'(io.o_data2);
      default: return int'(io.o_data3);
    endcase
  endfunction

  // Round half up by floor division, then clamp to 16-bit signed.
  function automatic int rs(input longint v, input int s);
    longint d, t, q;
    d = longint'(2) ** s;
    t = v + d / 2;
    q = t / d;
    if (t < 0 && (t % d) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Forward: Y = M X M^T; inverse: X = M^T Y M; rounding after each pass.
  function automatic void model(input bit inv);
    int z[4][4];
    longint acc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        acc = 0;
        for (int n = 0; n < 4; n++) acc += longint'(blk[i][n]) * (inv ? M[n][k] : M[k][n]);
        z[i][k] = rs(acc, inv ? 7 : 1);
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int i = 0; i < 4; i++) acc += longint'(inv ? M[i][r] : M[r][i]) * z[i][j];
        ex[r][j] = rs(acc, inv ? 12 : 8);
      end
  endfunction

  function automatic void rand_blk();
    logic signed [15:0] t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t = 16'($urandom);
        blk[i][j] = int'(t);
      end
  endfunction

  function automatic void fill_blk(input int v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) blk[i][j] = v;
  endfunction

  task automatic drive_block(input bit inv, input int gap, input bit tog);
    int guard;
    @(posedge clk); #1;
    for (int r = 0; r < 4; r++) begin
      io.i_valid = 1'b1;
      io.inverse = (tog && r > 0) ? ~inv : inv;
      io.i_row0 = 16'(blk[r][0]);
      io.i_row1 = 16'(blk[r][1]);
      io.i_row2 = 16'(blk[r][2]);
      io.i_row3 = 16'(blk[r][3]);
      guard = 0;
      @(negedge clk);
      while (!io.i_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 40) chk("ready_timeout", 0, 1);
      if (r == 0) a0 = cyc;
      a3 = cyc;
      @(posedge clk); #1;
      io.i_valid = 1'b0;
      if (tog) io.inverse = ~io.inverse;
      if (r < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic collect();
    int b, c;
    b = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      c = cyc;
      if (io.o_valid) begin
        if (b < 4) begin
          for (int r = 0; r < 4; r++) begin
            got[r][b] = od(r);
            chk($sformatf("data_b%0d_r%0d", b, r), got[r][b], ex[r][b]);
          end
          chk($sformatf("beat_cycle_b%0d", b), c - a3, 5 + b);
          chk($sformatf("last_b%0d", b), int'(io.o_last), int'(b == 3));
        end
        b++;
      end
      if (c == a3 + 8) chk("busy_at_last", int'(io.busy), 1);
      if (c == a3 + 9) begin
        chk("ready_after", int'(io.i_ready), 1);
        chk("busy_after", int'(io.busy), 0);
        chk("data_hold", od(0), ex[0][3]);
      end
    end
    chk("num_beats", b, 4);
  endtask

  task automatic run(input bit inv, input int gap, input bit tog);
    model(inv);
    drive_block(inv, gap, tog);
    collect();
  endtask

  initial begin
    int nb;
    bit inv;
    io.i_valid = 1'b0;
    io.inverse = 1'b0;
    io.i_row0 = '0; io.i_row1 = '0; io.i_row2 = '0; io.i_row3 = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_o_valid", int'(io.o_valid), 0);
    chk("rst_o_last", int'(io.o_last), 0);
    chk("rst_busy", int'(io.busy), 0);
    chk("rst_o_data0", od(0), 0);
    chk("rst_o_data3", od(3), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", int'(io.i_ready), 1);

    // Zero block, forward, back-to-back rows
    fill_blk(0);
    run(1'b0, 0, 1'b0);

    // Forward impulse
    fill_blk(0);
    blk[0][0] = 64;
    run(1'b0, 0, 1'b0);
    chk("imp_r0", got[0][0], 512);
    chk("imp_r1", got[1][0], 664);
    chk("imp_r2", got[2][0], 512);
    chk("imp_r3", got[3][0], 288);

    // Inverse DC
    fill_blk(0);
    blk[0][0] = 64;
    run(1'b1, 0, 1'b0);
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) chk($sformatf("idc_%0d_%0d", r, j), got[r][j], 1);

    // Inverse saturation case
    fill_blk(32767);
    run(1'b1, 0, 1'b0);

    // Gaps of 2 with inverse toggling after the first row
    rand_blk();
    run(1'b0, 2, 1'b1);
    chk("gap_span", a3 - a0, 9);
    rand_blk();
    run(1'b1, 2, 1'b1);

    // Reset during pass 2 must drop the block
    rand_blk();
    drive_block(1'b0, 0, 1'b0);
    while (cyc < a3 + 4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", int'(io.busy), 0);
    chk("midrst_o_valid", int'(io.o_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (io.o_valid) nb++;
    end
    chk("midrst_no_beats", nb, 0);
    rand_blk();
    run(1'b1, 0, 1'b0);

    // Random blocks
    for (int t = 0; t < 6; t++) begin
      rand_blk();
      inv = 1'($urandom_range(0, 1));
      run(inv, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
